// File: rtl/switch_conditioner.sv
// Per-channel input conditioning: optional inversion, two-flop synchronizer,
// counter debouncer and registered rise/fall pulses aligned with the level change.
module switch_conditioner #(
    parameter int               WIDTH           = 2,
    parameter int               DEBOUNCE_CYCLES = 4,
    parameter logic [WIDTH-1:0] ACTIVE_LOW      = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] s1_q, s1_d;
    logic [WIDTH-1:0] s2_q, s2_d;
    logic [WIDTH-1:0] level_q, level_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    // A channel only counts while its synchronized input disagrees with the
    // accepted level; any agreement drops the count, so bounce restarts it.
    always_comb begin
        s1_d    = raw_in ^ ACTIVE_LOW;
        s2_d    = s1_q;
        level_d = level_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != level_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    level_d[i] = s2_q[i];
                    rise_d[i]  = s2_q[i];
                    fall_d[i]  = ~s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q    <= '0;
            s2_q    <= '0;
            level_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: tb/tb_switch_conditioner.sv
// Scoreboard bench: stimulus queues the expected pulse events, monitors pop and
// compare whenever a DUT emits a rise/fall pulse.
module tb_switch_conditioner;

    typedef struct {
        int         at_edge;
        logic [1:0] lvl;
        logic [1:0] r;
        logic [1:0] f;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] raw, raw2;
    logic [1:0] level, rise, fall;
    logic [1:0] level2, rise2, fall2;
    int         edge_cnt = 0;
    int         n_checks = 0;
    int         n_fail   = 0;
    ev_t        exp_q[$];
    ev_t        exp2_q[$];

    switch_conditioner #(.WIDTH(2), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(2'b00)) dut (
        .clk(clk), .reset_n(reset_n), .raw_in(raw),
        .level(level), .rise(rise), .fall(fall)
    );

    switch_conditioner #(.WIDTH(2), .DEBOUNCE_CYCLES(1), .ACTIVE_LOW(2'b11)) dut2 (
        .clk(clk), .reset_n(reset_n), .raw_in(raw2),
        .level(level2), .rise(rise2), .fall(fall2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic checkOutput(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    task automatic pushEvent(input int which, input int at_edge,
                             input logic [1:0] lvl, input logic [1:0] r, input logic [1:0] f);
        ev_t e;
        e.at_edge = at_edge;
        e.lvl     = lvl;
        e.r       = r;
        e.f       = f;
        if (which == 1) exp_q.push_back(e);
        else            exp2_q.push_back(e);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [1:0] v);
        raw = v;
    endtask

    // Monitor for the default-parameter DUT
    always @(negedge clk) begin
        ev_t e;
        if (reset_n) begin
            checkOutput("dut_rise_and_fall", int'(rise & fall), 0);
            if (exp_q.size() > 0 && exp_q[0].at_edge < edge_cnt) begin
                e = exp_q.pop_front();
                checkOutput("dut_missed_pulse_edge", edge_cnt, e.at_edge);
            end
            if ((rise | fall) != 2'b00) begin
                if (exp_q.size() == 0) begin
                    checkOutput("dut_unexpected_pulse", int'({rise, fall}), 0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("dut_pulse_edge", edge_cnt, e.at_edge);
                    checkOutput("dut_level", int'(level), int'(e.lvl));
                    checkOutput("dut_rise", int'(rise), int'(e.r));
                    checkOutput("dut_fall", int'(fall), int'(e.f));
                end
            end
        end
    end

    // Monitor for the inverted, single-cycle-debounce DUT
    always @(negedge clk) begin
        ev_t e;
        if (reset_n) begin
            if (exp2_q.size() > 0 && exp2_q[0].at_edge < edge_cnt) begin
                e = exp2_q.pop_front();
                checkOutput("dut2_missed_pulse_edge", edge_cnt, e.at_edge);
            end
            if ((rise2 | fall2) != 2'b00) begin
                if (exp2_q.size() == 0) begin
                    checkOutput("dut2_unexpected_pulse", int'({rise2, fall2}), 0);
                end else begin
                    e = exp2_q.pop_front();
                    checkOutput("dut2_pulse_edge", edge_cnt, e.at_edge);
                    checkOutput("dut2_level", int'(level2), int'(e.lvl));
                    checkOutput("dut2_rise", int'(rise2), int'(e.r));
                    checkOutput("dut2_fall", int'(fall2), int'(e.f));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        raw     = 2'b00;
        raw2    = 2'b11;
        waitCycles(3);
        checkOutput("reset_level", int'(level), 0);
        checkOutput("reset_rise", int'(rise), 0);
        checkOutput("reset_fall", int'(fall), 0);
        checkOutput("reset_level2", int'(level2), 0);
        reset_n = 1'b1;

        // Inverted inputs held inactive: no pulse may follow release
        waitCycles(10);
        checkOutput("active_low_idle_level2", int'(level2), 0);

        // Single-cycle debounce accepts at edge 3, both directions
        raw2 = 2'b10;
        pushEvent(2, edge_cnt + 3, 2'b01, 2'b01, 2'b00);
        waitCycles(5);
        raw2 = 2'b11;
        pushEvent(2, edge_cnt + 3, 2'b00, 2'b00, 2'b01);
        waitCycles(5);
        checkOutput("dut2_level_after_fall", int'(level2), 0);

        // Clean rising step on channel 0
        applyStimulus(2'b01);
        pushEvent(1, edge_cnt + 6, 2'b01, 2'b01, 2'b00);
        waitCycles(8);
        checkOutput("step_level", int'(level), 1);
        checkOutput("step_rise_cleared", int'(rise), 0);

        // Three-cycle glitch on channel 1 must be rejected
        applyStimulus(2'b11);
        waitCycles(3);
        applyStimulus(2'b01);
        waitCycles(8);
        checkOutput("glitch_level", int'(level), 1);

        // Bring channel 0 low, then bounce it back up with 1,0,1,1,...
        applyStimulus(2'b00);
        pushEvent(1, edge_cnt + 6, 2'b00, 2'b00, 2'b01);
        waitCycles(8);
        pushEvent(1, edge_cnt + 8, 2'b01, 2'b01, 2'b00);
        applyStimulus(2'b01);
        waitCycles(1);
        applyStimulus(2'b00);
        waitCycles(1);
        applyStimulus(2'b01);
        waitCycles(10);
        checkOutput("bounce_level", int'(level), 1);

        // Both channels high, then both fall together
        applyStimulus(2'b11);
        pushEvent(1, edge_cnt + 6, 2'b11, 2'b10, 2'b00);
        waitCycles(8);
        applyStimulus(2'b00);
        pushEvent(1, edge_cnt + 6, 2'b00, 2'b00, 2'b11);
        waitCycles(8);
        checkOutput("dual_fall_level", int'(level), 0);

        // Reset while channel 0 is mid-count discards the partial count
        applyStimulus(2'b01);
        waitCycles(4);
        reset_n = 1'b0;
        #1;
        checkOutput("mid_debounce_reset_level", int'(level), 0);
        waitCycles(2);
        reset_n = 1'b1;
        pushEvent(1, edge_cnt + 6, 2'b01, 2'b01, 2'b00);
        waitCycles(9);
        checkOutput("post_reset_level", int'(level), 1);

        // Asynchronous reset clears a nonzero level between clock edges
        applyStimulus(2'b11);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async_reset_level", int'(level), 0);
        checkOutput("async_reset_rise", int'(rise), 0);
        checkOutput("async_reset_fall", int'(fall), 0);
        waitCycles(2);
        reset_n = 1'b1;
        pushEvent(1, edge_cnt + 6, 2'b11, 2'b11, 2'b00);
        waitCycles(10);
        checkOutput("final_level", int'(level), 3);
        checkOutput("final_level2", int'(level2), 0);

        checkOutput("dut_pending_events", exp_q.size(), 0);
        checkOutput("dut2_pending_events", exp2_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
